// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x oversampled 8N1 UART receiver with a one-deep holding register,
// valid/ready handshake and sticky framing-error / overrun flags.
module uart_rx_engine #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          sync1, rx_s, armed, v7, v8;
    logic [CW-1:0] cnt;
    logic [3:0]    sc;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          tick, maj;

    assign tick = cnt == CW'(DIV - 1);
    // sc=7 and sc=8 samples are held; the sc=9 sample is the live rx_s
    assign maj  = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            armed     <= 1'b0;
            state     <= IDLE;
            sc        <= 4'd0;
            idx       <= 3'd0;
            shift     <= 8'd0;
            v7        <= 1'b1;
            v8        <= 1'b1;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1 <= UART_RX;
            rx_s  <= sync1;
            cnt   <= tick ? '0 : cnt + 1'b1;
            if (tick && rx_s)
                armed <= 1'b1;
            // clears come first so that a same-edge set below takes priority
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (tick) begin
                if (state != IDLE) begin
                    sc <= sc + 4'd1;
                    if (sc == 4'd7) v7 <= rx_s;
                    if (sc == 4'd8) v8 <= rx_s;
                end
                case (state)
                    IDLE:
                        if (armed && !rx_s) begin
                            state <= START;
                            sc    <= 4'd1;
                        end
                    START:
                        if (sc == 4'd9 && maj)
                            state <= IDLE;
                        else if (sc == 4'd15) begin
                            state <= DATA;
                            idx   <= 3'd0;
                        end
                    DATA: begin
                        if (sc == 4'd9)
                            shift <= {maj, shift[7:1]};
                        if (sc == 4'd15) begin
                            idx <= idx + 3'd1;
                            if (idx == 3'd7)
                                state <= STOP;
                        end
                    end
                    STOP:
                        // leave half a bit early so back-to-back frames resync on the next start edge
                        if (sc == 4'd9) begin
                            state <= IDLE;
                            if (!maj)
                                frame_err <= 1'b1;
                            else if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else
                                overrun <= 1'b1;
                        end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed frames; expected bytes are queued at stimulus time and
// checked by an independent monitor whenever a new byte appears on rx_data/rx_valid.
module tb_uart_rx_engine;
    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       UART_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       pv = 1'b0;
    logic [7:0] pd = 8'd0;
    logic [7:0] mexp;

    uart_rx_engine #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rx_ready(rx_ready),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (reset && rx_valid && (!pv || rx_data !== pd)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL byte: got %h expected none", rx_data);
            end else begin
                mexp = q.pop_front();
                if (rx_data !== mexp) begin
                    errors++;
                    $display("FAIL byte: got %h expected %h", rx_data, mexp);
                end
            end
        end
        pv = reset & rx_valid;
        pd = rx_data;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic bitd(input logic v, input logic g);
        UART_RX = v;
        if (g) begin
            cycles(81);
            UART_RX = ~v;
            cycles(10);
            UART_RX = v;
            cycles(69);
        end else
            cycles(160);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int gbit);
        bitd(1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            bitd(b[i], i == gbit);
        bitd(stop, 1'b0);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        chk("valid_after_ready", {7'd0, rx_valid}, 8'd0);
    endtask

    initial begin
        int n;
        cycles(5);
        chk("reset_data", rx_data, 8'd0);
        chk("reset_valid", {7'd0, rx_valid}, 8'd0);
        chk("reset_ferr", {7'd0, frame_err}, 8'd0);
        chk("reset_ovr", {7'd0, overrun}, 8'd0);
        reset = 1'b1;
        cycles(50);

        // 0x55 with latency window
        q.push_back(8'h55);
        n = 0;
        fork
            send(8'h55, 1'b1, -1);
            begin
                while (!rx_valid && n < 1600) begin
                    cycles(1);
                    n++;
                end
                checks++;
                if (n < 1520 || n > 1560) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles expected 1520..1560", n);
                end
            end
        join
        chk("t1_valid", {7'd0, rx_valid}, 8'd1);
        chk("t1_ferr", {7'd0, frame_err}, 8'd0);
        consume();

        // short low pulse rejected, then 0x3C
        UART_RX = 1'b0;
        cycles(40);
        UART_RX = 1'b1;
        cycles(1600);
        chk("t2_valid", {7'd0, rx_valid}, 8'd0);
        chk("t2_ferr", {7'd0, frame_err}, 8'd0);
        q.push_back(8'h3C);
        send(8'h3C, 1'b1, -1);
        cycles(100);
        chk("t2b_valid", {7'd0, rx_valid}, 8'd1);
        consume();

        // framing error and clear
        send(8'hA3, 1'b0, -1);
        UART_RX = 1'b1;
        cycles(400);
        chk("t3_ferr", {7'd0, frame_err}, 8'd1);
        chk("t3_valid", {7'd0, rx_valid}, 8'd0);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk("t3_ferr_clr", {7'd0, frame_err}, 8'd0);

        // overrun on back-to-back frames
        q.push_back(8'h12);
        send(8'h12, 1'b1, -1);
        send(8'h34, 1'b1, -1);
        cycles(100);
        chk("t4_data", rx_data, 8'h12);
        chk("t4_valid", {7'd0, rx_valid}, 8'd1);
        chk("t4_ovr", {7'd0, overrun}, 8'd1);
        consume();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk("t4_ovr_clr", {7'd0, overrun}, 8'd0);
        cycles(200);

        // ready exactly on the second completion edge: frames are 1600 cycles apart
        q.push_back(8'h12);
        q.push_back(8'h34);
        n = 0;
        fork
            begin
                send(8'h12, 1'b1, -1);
                send(8'h34, 1'b1, -1);
            end
            begin
                while (!rx_valid && n < 2000) begin
                    cycles(1);
                    n++;
                end
                if (!rx_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL t4b_first: got valid 0 expected 1");
                end else begin
                    cycles(1599);
                    rx_ready = 1'b1;
                    cycles(1);
                    rx_ready = 1'b0;
                end
            end
        join
        cycles(100);
        chk("t4b_data", rx_data, 8'h34);
        chk("t4b_valid", {7'd0, rx_valid}, 8'd1);
        chk("t4b_ovr", {7'd0, overrun}, 8'd0);
        consume();

        // single-sample glitch in bit 2
        q.push_back(8'hFF);
        send(8'hFF, 1'b1, 2);
        cycles(100);
        chk("t5_data", rx_data, 8'hFF);
        consume();

        // reset mid-frame, released with the line low
        UART_RX = 1'b0;
        cycles(560);
        reset = 1'b0;
        cycles(20);
        chk("t6_rst_valid", {7'd0, rx_valid}, 8'd0);
        chk("t6_rst_data", rx_data, 8'd0);
        reset = 1'b1;
        cycles(300);
        chk("t6_low_valid", {7'd0, rx_valid}, 8'd0);
        chk("t6_low_ferr", {7'd0, frame_err}, 8'd0);
        UART_RX = 1'b1;
        cycles(200);
        q.push_back(8'hF0);
        send(8'hF0, 1'b1, -1);
        cycles(100);
        chk("t6_data", rx_data, 8'hF0);
        chk("t6_ferr", {7'd0, frame_err}, 8'd0);
        chk("t6_ovr", {7'd0, overrun}, 8'd0);
        consume();

        cycles(10);
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
